data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the CPU's MemRead/MemWrite data interface.
- Stores DEPTH words of 24 bits and latches one request at a time.
- Inserts WAIT_CYCLES wait states, then completes the request with a one-cycle Ready pulse.
- Replaces the zero-latency memory model so datapath stall logic can be exercised against realistic latency.

Parameters:
DATA_W, 24, data word width
ADDR_W, 8, word-address width
DEPTH, 256, number of implemented words (≤ 2^ADDR_W)
WAIT_CYCLES, 2, wait states between accept and response (0..15)

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
MemRead  input  1  read request, sampled only in IDLE
MemWrite  input  1  write request, sampled only in IDLE
Address  input  ADDR_W  word address, latched on accept
WriteData  input  DATA_W  write data, latched on accept
ReadData  output  DATA_W  registered read data, held until next completed read
Ready  output  1  one-cycle completion pulse
Busy  output  1  high whenever state ≠ IDLE
Error  output  1  valid only with Ready; flags a rejected request

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State IDLE; counter 0.
  - ReadData=0, Ready=0, Busy=0, Error=0.
  - Latched Address, WriteData and op cleared.
  - Memory array is NOT cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with MemRead|MemWrite=1: latch Address, WriteData and op (RD, WR, or BAD when both are high).
  - Load counter with WAIT_CYCLES. Next state is WAIT, or RESP if WAIT_CYCLES=0.
  - With no request, stay in IDLE.
- WAIT:
  - Counter decrements each edge. When counter=1 at an edge, next state is RESP.
  - All inputs are ignored; changes to Address or WriteData have no effect.
- Edge entering RESP:
  - RD with latched Address<DEPTH: ReadData <= mem[Address].
  - RD with Address≥DEPTH: ReadData <= 0, error flagged.
  - WR with Address<DEPTH: mem[Address] <= WriteData.
  - WR with Address≥DEPTH: no write, error flagged.
  - BAD: no memory access, ReadData unchanged, error flagged.
- RESP:
  - Ready=1 for exactly one cycle; Error=1 if flagged. Next state is always IDLE.
  - Busy=1 during RESP.
  - A request present during RESP is not accepted. Earliest next accept is the edge ending the following IDLE cycle.
- Timing:
  - Latency = WAIT_CYCLES+1 cycles from the accept edge to the Ready cycle.
  - Throughput = one request per WAIT_CYCLES+2 cycles.
- Outputs: Ready, Error and Busy are registered (decoded from registered state/flags); no combinational input-to-output paths.
- Error is 0 whenever Ready=0.
- ReadData changes only on the edge entering RESP of an RD request (or on reset). Writes and BAD requests leave it unchanged.
- Reset mid-operation: pending request is abandoned, and a pending write is never committed. Returns to IDLE immediately, with no Ready pulse.
- Counter width is 4 bits. WAIT_CYCLES=0 bypasses WAIT entirely.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write Address=0x05, WriteData=0xABCDEF, accepted at edge t0 -> Ready=1, Error=0 in cycle t0+3; Busy=1 over t0+1..t0+3.
  - Read Address=0x05 issued in the next IDLE cycle -> ReadData=0xABCDEF with Ready=1, 3 cycles after its accept edge.
- Input ignored while busy: during WAIT change Address to 0x06 and WriteData to 0x123456 after write 0x111111 to 0x05 -> mem[0x05]=0x111111, mem[0x06] unchanged. A MemRead held high through RESP is accepted only in the next IDLE cycle.
- Error cases, DEPTH=200, Address=0xC8:
  - Read -> Ready=1, Error=1, ReadData=0.
  - MemRead=MemWrite=1 at Address=0x05 -> Ready=1, Error=1, mem[0x05] and ReadData unchanged.
- WAIT_CYCLES=0: read accepted at t0 -> Ready in cycle t0+1. Back-to-back held MemRead -> a Ready pulse every 2 cycles.
- Reset mid-write: write 0x777777 to 0x10 (mem[0x10]=0x000001 beforehand), assert Reset_n=0 during WAIT -> all outputs 0 asynchronously, no Ready pulse, mem[0x10] still 0x000001 after release.
- Reset between transactions: prior ReadData=0xABCDEF -> ReadData=0 after reset, while memory contents are retained (a read of the previously written address returns the old value).

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one MemRead/MemWrite request, waits
// WAIT_CYCLES, then completes it with a one-cycle Ready pulse (Error flags rejects).
module data_mem_responder #(
   parameter int DATA_W      = 24,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              i_Clock,
   input  logic              i_Reset_n,
   input  logic              i_MemRead,
   input  logic              i_MemWrite,
   input  logic [ADDR_W-1:0] i_Address,
   input  logic [DATA_W-1:0] i_WriteData,
   output logic [DATA_W-1:0] o_ReadData,
   output logic              o_Ready,
   output logic              o_Busy,
   output logic              o_Error
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_BAD} op_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t            r_state, w_state_next;
   logic [3:0]        r_cnt, w_cnt_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   op_t               r_op;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_in_range;
   op_t               w_req_op;
   op_t               w_acc_op;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [DATA_W-1:0] w_acc_data;

   assign w_accept     = (r_state == S_IDLE) && (i_MemRead || i_MemWrite);
   assign w_enter_resp = (w_state_next == S_RESP);

   // With WAIT_CYCLES=0 the access happens on the accept edge itself, so the
   // memory operation must use the live request rather than the latched one.
   always_comb begin
      w_req_op = OP_NONE;
      if (i_MemRead && i_MemWrite) w_req_op = OP_BAD;
      else if (i_MemRead)          w_req_op = OP_RD;
      else if (i_MemWrite)         w_req_op = OP_WR;

      w_acc_op   = r_op;
      w_acc_addr = r_addr;
      w_acc_data = r_wdata;
      if (r_state == S_IDLE) begin
         w_acc_op   = w_req_op;
         w_acc_addr = i_Address;
         w_acc_data = i_WriteData;
      end
   end

   assign w_in_range = (32'(w_acc_addr) < DEPTH);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cnt_next   = WAIT_LD;
               w_state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) w_state_next = S_RESP;
         end
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_op    <= OP_NONE;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_addr  <= i_Address;
            r_wdata <= i_WriteData;
            r_op    <= w_req_op;
         end
         if (w_enter_resp) begin
            r_err <= (w_acc_op == OP_BAD) || !w_in_range;
            if (w_acc_op == OP_RD)
               r_rdata <= w_in_range ? r_mem[w_acc_addr] : '0;
         end
      end
   end

   // Memory is deliberately outside the reset domain; an async reset before the
   // edge entering RESP keeps the pending write from ever reaching the array.
   always_ff @(posedge i_Clock) begin
      if (i_Reset_n && w_enter_resp && (w_acc_op == OP_WR) && w_in_range)
         r_mem[w_acc_addr] <= w_acc_data;
   end

   assign o_ReadData = r_rdata;
   assign o_Ready    = (r_state == S_RESP);
   assign o_Busy     = (r_state != S_IDLE);
   assign o_Error    = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with DEPTH=200/WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0, each checked against an array-based transaction model.
module tb_data_mem_responder;
   localparam int DEPTH_A = 200;
   localparam int WC_A    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_rd, a_wr, z_rd, z_wr;
   logic [7:0]  a_addr, z_addr;
   logic [23:0] a_wdata, z_wdata, a_rdata, z_rdata;
   logic        a_ready, a_busy, a_err, z_ready, z_busy, z_err;

   int total = 0;
   int bad   = 0;

   logic [23:0] m_mem  [0:255];
   logic [23:0] m0_mem [0:255];
   logic [23:0] m_rd, m0_rd;

   always #5 clk = ~clk;

   data_mem_responder #(.DATA_W(24), .ADDR_W(8), .DEPTH(DEPTH_A), .WAIT_CYCLES(WC_A)) dut (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_MemRead(a_rd), .i_MemWrite(a_wr),
      .i_Address(a_addr), .i_WriteData(a_wdata), .o_ReadData(a_rdata),
      .o_Ready(a_ready), .o_Busy(a_busy), .o_Error(a_err));

   data_mem_responder #(.DATA_W(24), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_MemRead(z_rd), .i_MemWrite(z_wr),
      .i_Address(z_addr), .i_WriteData(z_wdata), .o_ReadData(z_rdata),
      .o_Ready(z_ready), .o_Busy(z_busy), .o_Error(z_err));

   // One complete request on the WAIT_CYCLES=2 instance; expected outcome comes
   // from the model: latency WC_A+1, Busy across it, ReadData held until Ready.
   task automatic run_txn(input bit rd, input bit wr, input logic [7:0] a,
                          input logic [23:0] d, input bit junk);
      int k;
      bit got;
      bit exp_err;
      logic [23:0] prev_rd;
      prev_rd = m_rd;
      exp_err = (rd && wr) || (int'(a) >= DEPTH_A);
      if (rd && !wr) m_rd = (int'(a) < DEPTH_A) ? m_mem[a] : 24'h0;
      if (wr && !rd && int'(a) < DEPTH_A) m_mem[a] = d;

      @(negedge clk);
      total++;
      if (a_busy !== 1'b0 || a_ready !== 1'b0)
         begin bad++; $display("FAIL idle_before busy=%b ready=%b required 0/0", a_busy, a_ready); end
      a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
      @(negedge clk);
      a_rd = 1'b0; a_wr = 1'b0;
      if (junk) begin a_addr = a + 8'd1; a_wdata = 24'h123456; end
      k = 1; got = 0;
      while (!got && k <= WC_A + 4) begin
         if (k > 1) @(negedge clk);
         total++;
         if (a_busy !== 1'b1) begin bad++; $display("FAIL busy k=%0d got=%b required 1", k, a_busy); end
         if (a_ready === 1'b1) begin
            got = 1;
            total++;
            if (k != WC_A + 1) begin bad++; $display("FAIL latency got=%0d required %0d", k, WC_A + 1); end
            total++;
            if (a_err !== exp_err) begin bad++; $display("FAIL error a=%h got=%b required %b", a, a_err, exp_err); end
            total++;
            if (a_rdata !== m_rd) begin bad++; $display("FAIL rdata a=%h got=%h required %h", a, a_rdata, m_rd); end
         end else begin
            total++;
            if (a_err !== 1'b0 || a_rdata !== prev_rd)
               begin bad++; $display("FAIL wait_outputs k=%0d err=%b rdata=%h required 0/%h", k, a_err, a_rdata, prev_rd); end
         end
         k++;
      end
      if (!got) begin total++; bad++; $display("FAIL ready_timeout a=%h got none required pulse", a); end
      $display("txn rd=%b wr=%b addr=%h data=%h err=%b rdata=%h", rd, wr, a, d, a_err, a_rdata);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
      z_rd = 0; z_wr = 0; z_addr = 0; z_wdata = 0;
      m_rd = 0; m0_rd = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({a_ready, a_busy, a_err, a_rdata} !== 27'h0 || {z_ready, z_busy, z_err, z_rdata} !== 27'h0)
         begin bad++; $display("FAIL reset_outputs a=%b%b%b/%h z=%b%b%b/%h required all 0",
                               a_ready, a_busy, a_err, a_rdata, z_ready, z_busy, z_err, z_rdata); end
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_write_read();
      run_txn(1'b0, 1'b1, 8'h05, 24'hABCDEF, 1'b0);
      run_txn(1'b1, 1'b0, 8'h05, 24'h000000, 1'b0);
   endtask

   task automatic test_busy_ignore();
      run_txn(1'b0, 1'b1, 8'h06, 24'h666666, 1'b0);
      run_txn(1'b0, 1'b1, 8'h05, 24'h111111, 1'b1);
      run_txn(1'b1, 1'b0, 8'h06, 24'h0, 1'b0);
      run_txn(1'b1, 1'b0, 8'h05, 24'h0, 1'b0);
      // MemRead held high through RESP: second accept only at end of next IDLE.
      @(negedge clk);
      a_rd = 1'b1; a_addr = 8'h06;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) a_rd = 1'b0;
         total++;
         if (a_ready !== (k == 3 || k == 7) || a_busy !== (k != 4))
            begin bad++; $display("FAIL held_read k=%0d ready=%b busy=%b required %b/%b",
                                  k, a_ready, a_busy, (k == 3 || k == 7), (k != 4)); end
      end
      m_rd = m_mem[8'h06];
      total++;
      if (a_rdata !== m_rd) begin bad++; $display("FAIL held_read_data got=%h required %h", a_rdata, m_rd); end
      $display("held read pair done rdata=%h", a_rdata);
   endtask

   task automatic test_errors();
      run_txn(1'b1, 1'b0, 8'hC8, 24'h0, 1'b0);
      run_txn(1'b1, 1'b0, 8'h05, 24'h0, 1'b0);
      run_txn(1'b1, 1'b1, 8'h05, 24'h999999, 1'b0);
      run_txn(1'b0, 1'b1, 8'hFF, 24'h424242, 1'b0);
      run_txn(1'b1, 1'b0, 8'h05, 24'h0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) run_txn(1'b0, 1'b1, 8'(i), 24'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) begin
         int sel;
         logic [7:0] a;
         sel = $urandom_range(0, 99);
         a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 15));
         if (sel < 45)      run_txn(1'b1, 1'b0, a, 24'h0, 1'b0);
         else if (sel < 90) run_txn(1'b0, 1'b1, a, 24'($urandom), 1'b0);
         else               run_txn(1'b1, 1'b1, a, 24'($urandom), 1'b0);
      end
   endtask

   task automatic test_reset_between();
      run_txn(1'b0, 1'b1, 8'h20, 24'hABCDEF, 1'b0);
      run_txn(1'b1, 1'b0, 8'h20, 24'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      m_rd = 24'h0; m0_rd = 24'h0;
      @(negedge clk);
      total++;
      if (a_rdata !== 24'h0) begin bad++; $display("FAIL reset_rdata got=%h required 000000", a_rdata); end
      rst_n = 1'b1;
      run_txn(1'b1, 1'b0, 8'h20, 24'h0, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      run_txn(1'b0, 1'b1, 8'h10, 24'h000001, 1'b0);
      @(negedge clk);
      a_wr = 1'b1; a_addr = 8'h10; a_wdata = 24'h777777;
      @(negedge clk);
      a_wr = 1'b0;
      #1 rst_n = 1'b0;
      m_rd = 24'h0; m0_rd = 24'h0;
      #1;
      total++;
      if ({a_ready, a_busy, a_err, a_rdata} !== 27'h0)
         begin bad++; $display("FAIL async_reset ready=%b busy=%b err=%b rdata=%h required all 0",
                               a_ready, a_busy, a_err, a_rdata); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (a_ready !== 1'b0 || a_busy !== 1'b0)
            begin bad++; $display("FAIL post_reset_idle k=%0d ready=%b busy=%b required 0/0", k, a_ready, a_busy); end
      end
      run_txn(1'b1, 1'b0, 8'h10, 24'h0, 1'b0);
   endtask

   task automatic test_zero_wait();
      logic [7:0] addrs [0:4];
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (z_ready !== 1'b0 || z_busy !== 1'b0)
            begin bad++; $display("FAIL zw_idle i=%0d ready=%b busy=%b required 0/0", i, z_ready, z_busy); end
         z_wr = 1'b1; z_addr = 8'(i * 3); z_wdata = 24'($urandom);
         m0_mem[z_addr] = z_wdata;
         @(negedge clk);
         z_wr = 1'b0;
         total++;
         if (z_ready !== 1'b1 || z_busy !== 1'b1 || z_err !== 1'b0 || z_rdata !== m0_rd)
            begin bad++; $display("FAIL zw_write i=%0d ready=%b busy=%b err=%b rdata=%h required 1/1/0/%h",
                                  i, z_ready, z_busy, z_err, z_rdata, m0_rd); end
      end
      for (int i = 0; i < 5; i++) addrs[i] = 8'($urandom_range(0, 7) * 3);
      @(negedge clk);
      z_rd = 1'b1; z_addr = addrs[0];
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         total++;
         if (k % 2 == 1) begin
            m0_rd = m0_mem[addrs[(k - 1) / 2]];
            if (z_ready !== 1'b1 || z_rdata !== m0_rd)
               begin bad++; $display("FAIL zw_read k=%0d ready=%b rdata=%h required 1/%h", k, z_ready, z_rdata, m0_rd); end
            if (k < 9) z_addr = addrs[(k + 1) / 2];
            else z_rd = 1'b0;
         end else begin
            if (z_ready !== 1'b0 || z_busy !== 1'b0)
               begin bad++; $display("FAIL zw_gap k=%0d ready=%b busy=%b required 0/0", k, z_ready, z_busy); end
         end
         $display("zw cycle k=%0d ready=%b rdata=%h", k, z_ready, z_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_busy_ignore();
      test_errors();
      test_random();
      test_reset_between();
      test_reset_mid_write();
      test_zero_wait();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "timeout");
   end
endmodule
